// File: rtl/dsn_pkg.sv
// Shared encodings and constants for the DSN Read ROM sequencer and its CRC-8 helper.
package dsn_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_INIT = 3'd1,
    PH_CMD  = 3'd2,
    PH_READ = 3'd3,
    PH_FIN  = 3'd4
  } phase_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } slot_t;

  localparam logic [7:0] DSN_CMD_READ_ROM = 8'h33;
  localparam logic [7:0] DSN_CRC_POLY     = 8'h8C;
  localparam int         DSN_ROM_BITS     = 64;

  // One bit of the reflected Dallas CRC-8; a clean ROM leaves the register at zero.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return (crc >> 1) ^ (fb ? DSN_CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/dsn_rom_seq_if.sv
// Sequencer-to-bit-engine slot handshake: start/busy per slot, write data held for the slot.
interface dsn_rom_seq_if;
  logic dsn_start;
  logic dsn_wr_data;
  logic dsn_wr_init;
  logic dsn_busy;
  logic dsn_rd_data;

  modport master (
    output dsn_start, dsn_wr_data, dsn_wr_init,
    input  dsn_busy, dsn_rd_data
  );

  modport slave (
    input  dsn_start, dsn_wr_data, dsn_wr_init,
    output dsn_busy, dsn_rd_data
  );
endinterface

// File: rtl/dsn_crc8.sv
// Serial Dallas CRC-8 register: synchronous clear, one bit per enabled cycle, result registered.
module dsn_crc8
  import dsn_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);
  logic [7:0] r_crc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_crc <= 8'h00;
    end else if (i_clr) begin
      r_crc <= 8'h00;
    end else if (i_en) begin
      r_crc <= crc8_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;
endmodule

// File: rtl/dsn_rom_seq.sv
// Read ROM sequencer: init slot, 0x33 LSB-first, 64 read slots through the bit engine, CRC-8 check.
// go edge to first dsn_start is 2 cycles, last sample to done is 2 cycles; each slot stalls on engine busy.
module dsn_rom_seq
  import dsn_pkg::*;
#(
  parameter int MXTMO = 20,
  parameter int GAP   = 3
) (
  input  logic                    clock,
  input  logic                    global_reset,
  input  logic                    go,
  dsn_rom_seq_if.master           eng,
  output logic                    busy,
  output logic                    done,
  output logic                    crc_ok,
  output logic                    timeout,
  output logic [DSN_ROM_BITS-1:0] dsn_data
);
  localparam int            GW       = $clog2(GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [6:0]    LAST_BIT = 7'(DSN_ROM_BITS - 1);

  phase_t                  r_phase;
  slot_t                   r_slot;
  logic                    r_go_q;
  logic [MXTMO-1:0]        r_wd;
  logic [GW-1:0]           r_gap;
  logic [6:0]              r_bit_cnt;
  logic                    r_start;
  logic                    r_wr_data;
  logic                    r_wr_init;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_crc_ok;
  logic                    r_timeout;
  logic [DSN_ROM_BITS-1:0] r_data;

  logic       w_start_txn;
  logic       w_active;
  logic       w_sample;
  logic       w_abort;
  logic       w_crc_en;
  logic [7:0] w_crc;
  logic [7:0] w_cmd;
  logic [2:0] w_cmd_idx;

  assign w_cmd       = DSN_CMD_READ_ROM;
  assign w_cmd_idx   = r_bit_cnt[2:0] + 3'd1;
  assign w_start_txn = go && !r_go_q && (r_phase == PH_IDLE) && !r_busy;
  assign w_active    = (r_phase == PH_INIT) || (r_phase == PH_CMD) || (r_phase == PH_READ);
  assign w_sample    = w_active && (r_slot == S_WAIT) && !eng.dsn_busy;
  // A busy fall on the terminal count is a good sample, so the abort only fires while still waiting.
  assign w_abort     = w_active && (r_wd == '1) &&
                       ((r_slot == S_ASSERT) || ((r_slot == S_WAIT) && eng.dsn_busy));
  assign w_crc_en    = w_sample && (r_phase == PH_READ);

  dsn_crc8 u_crc (
    .i_clk (clock),
    .i_rst (global_reset),
    .i_clr (w_start_txn),
    .i_en  (w_crc_en),
    .i_bit (eng.dsn_rd_data),
    .o_crc (w_crc)
  );

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      r_phase   <= PH_IDLE;
      r_slot    <= S_IDLE;
      r_go_q    <= 1'b0;
      r_wd      <= '0;
      r_gap     <= '0;
      r_bit_cnt <= '0;
      r_start   <= 1'b0;
      r_wr_data <= 1'b0;
      r_wr_init <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_crc_ok  <= 1'b0;
      r_timeout <= 1'b0;
      r_data    <= '0;
    end else begin
      r_go_q <= go;
      r_done <= 1'b0;
      case (r_phase)
        PH_IDLE: begin
          r_slot  <= S_IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          if (w_start_txn) begin
            r_phase   <= PH_INIT;
            r_busy    <= 1'b1;
            r_data    <= '0;
            r_crc_ok  <= 1'b0;
            r_timeout <= 1'b0;
            r_bit_cnt <= '0;
            r_wr_init <= 1'b1;
            r_wr_data <= 1'b1;
          end
        end
        PH_INIT, PH_CMD, PH_READ: begin
          if (w_abort) begin
            r_start   <= 1'b0;
            r_timeout <= 1'b1;
            r_crc_ok  <= 1'b0;
            r_done    <= 1'b1;
            r_phase   <= PH_IDLE;
            r_slot    <= S_IDLE;
          end else begin
            case (r_slot)
              S_IDLE: begin
                r_slot  <= S_ASSERT;
                r_start <= 1'b1;
                r_wd    <= '0;
              end
              S_ASSERT: begin
                r_wd <= r_wd + MXTMO'(1);
                if (eng.dsn_busy) r_slot <= S_WAIT;
              end
              S_WAIT: begin
                if (eng.dsn_busy) begin
                  r_wd <= r_wd + MXTMO'(1);
                end else begin
                  r_start <= 1'b0;
                  r_slot  <= S_GAP;
                  r_gap   <= '0;
                  if (r_phase == PH_READ) begin
                    r_data <= {eng.dsn_rd_data, r_data[DSN_ROM_BITS-1:1]};
                    // Last bit skips the gap so done lands two cycles after the sample.
                    if (r_bit_cnt == LAST_BIT) begin
                      r_phase   <= PH_FIN;
                      r_slot    <= S_IDLE;
                      r_bit_cnt <= '0;
                    end
                  end
                end
              end
              S_GAP: begin
                if (r_gap != GAP_LAST) begin
                  r_gap <= r_gap + GW'(1);
                end else begin
                  r_slot    <= S_ASSERT;
                  r_start   <= 1'b1;
                  r_wd      <= '0;
                  r_wr_init <= 1'b0;
                  case (r_phase)
                    PH_INIT: begin
                      r_phase   <= PH_CMD;
                      r_bit_cnt <= '0;
                      r_wr_data <= w_cmd[0];
                    end
                    PH_CMD: begin
                      if (r_bit_cnt == 7'd7) begin
                        r_phase   <= PH_READ;
                        r_bit_cnt <= '0;
                        r_wr_data <= 1'b1;
                      end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                        r_wr_data <= w_cmd[w_cmd_idx];
                      end
                    end
                    default: begin
                      r_bit_cnt <= r_bit_cnt + 7'd1;
                      r_wr_data <= 1'b1;
                    end
                  endcase
                end
              end
              default: begin
                r_slot  <= S_IDLE;
                r_start <= 1'b0;
              end
            endcase
          end
        end
        PH_FIN: begin
          r_crc_ok <= (w_crc == 8'h00);
          r_done   <= 1'b1;
          r_phase  <= PH_IDLE;
        end
        default: begin
          r_phase <= PH_IDLE;
          r_slot  <= S_IDLE;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  assign eng.dsn_start   = r_start;
  assign eng.dsn_wr_data = r_wr_data;
  assign eng.dsn_wr_init = r_wr_init;
  assign busy            = r_busy;
  assign done            = r_done;
  assign crc_ok          = r_crc_ok;
  assign timeout         = r_timeout;
  assign dsn_data        = r_data;
endmodule

// File: doc/dsn_rom_seq.md
# dsn_rom_seq

Sequencer that drives the single-slot DSN bit engine (`dsn_alct`) through a complete 1-Wire Read ROM transaction and returns the result.
- Transaction: init slot, command 0x33 sent LSB-first, then 64 read slots.
- Assembles the 64-bit serial number and checks its Dallas CRC-8.
- Sits directly upstream of the bit engine. It owns that engine's `start`, `wr_data` and `wr_init`, and consumes its `busy` and `rd_data`.
- A slow-control register stage reads the results.

## Interface
Parameters:
- `MXTMO`, 20: slot watchdog counter width. A slot aborts at count 2^MXTMO−1 (≈26 ms at 40 MHz).
- `GAP`, 3: idle cycles with `dsn_start` low between slots. Minimum 2.

Ports:
- `clock`  in  1: 40 MHz clock.
- `global_reset`  in  1: asynchronous, active-high reset.
- `go`  in  1: level request. A rising edge starts one transaction.
- `dsn_start`  out  1: to bit engine `start`.
- `dsn_wr_data`  out  1: to bit engine `wr_data`.
- `dsn_wr_init`  out  1: to bit engine `wr_init`.
- `dsn_busy`  in  1: from bit engine `busy`.
- `dsn_rd_data`  in  1: from bit engine `rd_data`.
- `busy`  out  1: transaction in progress.
- `done`  out  1: one-cycle pulse at end of transaction.
- `crc_ok`  out  1: CRC over all 64 bits is zero. Held until the next transaction starts.
- `timeout`  out  1: watchdog abort. Held until the next transaction starts.
- `dsn_data`  out  64: serial number. Bit 0 is the first bit received; bits 7:0 are the family code; bits 63:56 are the CRC byte.

## Operation
- Reset values: all outputs 0, `dsn_data` = 0, phase = IDLE, slot sub-state = S_IDLE.
- `go` rising-edge detect:
  - uses a registered copy of `go`;
  - an edge during `busy` is ignored.
- Transaction start: clears `dsn_data`, CRC register (to 0x00), `crc_ok`, `timeout` and the bit counter.

Phase FSM:
- IDLE → INIT on a `go` edge.
- INIT: one slot with `dsn_wr_init`=1. `dsn_rd_data` is ignored. → CMD.
- CMD: 8 slots with `dsn_wr_init`=0 and `dsn_wr_data` = bit[n] of 0x33, n = 0..7 (sequence 1,1,0,0,1,1,0,0). → READ.
- READ: 64 slots with `dsn_wr_data`=1. Each sampled bit is shifted into `dsn_data` from the MSB end (so the first bit ends at bit 0) and fed to the CRC. → FIN.
- FIN: `crc_ok` <= (crc==0); `done`=1 for one cycle. → IDLE.
- Phase-FSM encoding is safe: an illegal state returns to IDLE.

Slot sub-FSM (per slot):
- S_ASSERT: `dsn_start`=1. Waits for `dsn_busy`=1. → S_WAIT.
- S_WAIT: `dsn_start`=1. Waits for `dsn_busy`=0. On that edge, samples `dsn_rd_data` (the engine holds it). → S_GAP.
- S_GAP: `dsn_start`=0 for `GAP` cycles. Then either the next slot (S_ASSERT) or the phase advance.
- Slot sub-FSM encoding is safe: an illegal state returns to S_IDLE.

Signal stability and counters:
- `dsn_wr_data` and `dsn_wr_init` are registered, set in S_GAP/entry, and stable throughout S_ASSERT and S_WAIT.
- Bit counter: 7 bits, 0..63. It wraps to 0 only on phase change and never overflows.
- CRC-8, reflected polynomial 0x8C: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? 8'h8C : 0). Updated only on READ samples.

Watchdog:
- Counts cycles in S_ASSERT+S_WAIT and clears on each slot entry.
- At terminal count: `dsn_start`=0, `timeout`=1, `done` pulse, `crc_ok`=0, → IDLE.

## Timing
- `go` edge to `dsn_start` high: 2 cycles.
- `dsn_busy` fall to `dsn_start` low: 1 cycle. `dsn_start` then stays low for ≥`GAP` cycles, which lets the engine reach idle.
- Last READ sample to `done`: 2 cycles. `crc_ok` and `dsn_data` are valid in the same cycle as `done`.
- `busy` is high from the cycle after the `go` edge through the `done` cycle inclusive.
- Asynchronous reset mid-slot:
  - `dsn_start` drops immediately and all outputs return to their reset values;
  - no `done` pulse is generated;
  - the bit engine shares `global_reset`.
- Simultaneous watchdog terminal count and `dsn_busy` fall: the sample wins and the slot completes normally.

## Structure
- Package `dsn_pkg`:
  - phase and slot state encodings;
  - `DSN_CMD_READ_ROM` = 8'h33;
  - `DSN_CRC_POLY` = 8'h8C;
  - `DSN_ROM_BITS` = 64.
- One sub-module: `dsn_crc8` (clear, enable, bit in, crc out), reusable for the TMB variant.

## Test plan
- Bit-engine model returning ROM bytes 02 1C B8 01 00 00 00 A2, `go` pulse → exactly 73 slots; `dsn_data` = 64'hA2000000_01B81C02; `crc_ok`=1; `done` pulse; `timeout`=0.
- Same model with the last byte 0xA3 → `dsn_data` = 64'hA3000000_01B81C02, `crc_ok`=0.
- Monitor `dsn_wr_init`/`dsn_wr_data` at each `dsn_start` rise → 1/x, then 0/1,1,0,0,1,1,0,0, then 0/1 ×64. No change while `dsn_start`=1.
- Model never asserts `dsn_busy` (MXTMO=6 override) → `timeout`=1 and `done` at cycle 2^6−1 of slot 1; `dsn_start` low; `busy` low next cycle.
- `global_reset` pulsed during READ slot 30, then `go` → all outputs 0 with no `done`; the new transaction completes correctly with `crc_ok`=1.
- Second `go` edge during a transaction → ignored; exactly one `done` pulse.
